// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative instruction cache with tree pseudo-LRU
// replacement, fence.i flush and saturating hit/miss counters. Hits are served
// combinationally in the request cycle; a miss fetches one full line from the
// DDR port, refills the victim way and then re-looks-up the held request.
module icache_assoc #(
  parameter int unsigned total_size_bytes = 1024,
  parameter int unsigned num_ways         = 4,
  parameter int unsigned line_size_bytes  = 16,
  parameter int unsigned word_size_bytes  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  ifetch_icache_addr,
  input  logic                         ifetch_icache_read,
  input  logic                         ifetch_icache_flush,
  output logic [31:0]                  icache_ifetch_rdata,
  output logic                         icache_ifetch_resp,
  output logic [31:0]                  icache_iddr_addr,
  output logic                         icache_iddr_read,
  input  logic [line_size_bytes*8-1:0] iddr_icache_rdata,
  input  logic                         iddr_icache_resp,
  output logic [31:0]                  icache_hit_count,
  output logic [31:0]                  icache_miss_count
);

  localparam int unsigned LINE_BITS  = line_size_bytes * 8;
  localparam int unsigned WORD_BITS  = word_size_bytes * 8;
  localparam int unsigned WORDS      = line_size_bytes / word_size_bytes;
  localparam int unsigned NUM_SETS   = total_size_bytes / (line_size_bytes * num_ways);
  localparam int unsigned OFFSET_W   = $clog2(line_size_bytes);
  localparam int unsigned INDEX_W    = $clog2(NUM_SETS);
  localparam int unsigned TAG_W      = 32 - OFFSET_W - INDEX_W;
  localparam int unsigned WAY_W      = $clog2(num_ways);
  localparam int unsigned WORD_OFF_W = $clog2(word_size_bytes);

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_FETCH
  } state_t;

  // Storage arrays, indexed [set][way]
  logic [num_ways-1:0]  r_valid [NUM_SETS];
  logic [num_ways-2:0]  r_plru  [NUM_SETS];
  logic [TAG_W-1:0]     r_tag   [NUM_SETS][num_ways];
  logic [LINE_BITS-1:0] r_data  [NUM_SETS][num_ways];

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_iddr_addr;
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;
  logic        r_flush_pending;

  // Lookup side (request address)
  logic [INDEX_W-1:0]   w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic [OFFSET_W-1:0]  w_word_idx;
  logic                 w_hit;
  logic [WAY_W-1:0]     w_hit_way;
  logic [LINE_BITS-1:0] w_hit_line;
  logic [WORD_BITS-1:0] w_hit_word;

  // Refill side (registered miss address)
  logic [INDEX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0]   w_fill_tag;
  logic [WAY_W-1:0]   w_victim;
  logic               w_free_found;

  logic w_flush_now;
  logic w_lookup;
  logic w_hit_serve;
  logic w_miss;
  logic w_refill;

  // Follow the tree from the root; each bit points toward the victim side.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [num_ways-2:0] bits);
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] way;
    logic             d;
    node = '0;
    way  = '0;
    for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
      d = bits[node];
      way[WAY_W-1-lvl] = d;
      node = (node << 1) + WAY_W'(1) + WAY_W'(d);
    end
    return way;
  endfunction

  // Make every node on the accessed way's path point away from it.
  function automatic logic [num_ways-2:0] plru_touch(input logic [num_ways-2:0] bits,
                                                     input logic [WAY_W-1:0]    way);
    logic [num_ways-2:0] res;
    logic [WAY_W-1:0]    node;
    logic                d;
    res  = bits;
    node = '0;
    for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
      d = way[WAY_W-1-lvl];
      res[node] = ~d;
      node = (node << 1) + WAY_W'(1) + WAY_W'(d);
    end
    return res;
  endfunction

  assign w_idx      = ifetch_icache_addr[OFFSET_W +: INDEX_W];
  assign w_tag      = ifetch_icache_addr[31 -: TAG_W];
  assign w_word_idx = ifetch_icache_addr[OFFSET_W-1:0] >> WORD_OFF_W;
  assign w_fill_idx = r_iddr_addr[OFFSET_W +: INDEX_W];
  assign w_fill_tag = r_iddr_addr[31 -: TAG_W];

  // Tag compare across all ways of the requested set
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int unsigned w = 0; w < num_ways; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Select the requested word out of the hit line
  always_comb begin
    w_hit_line = r_data[w_idx][w_hit_way];
    w_hit_word = '0;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (w_word_idx == OFFSET_W'(k)) begin
        w_hit_word = w_hit_line[k*WORD_BITS +: WORD_BITS];
      end
    end
  end

  // Victim: lowest invalid way first, otherwise the PLRU choice
  always_comb begin
    w_free_found = 1'b0;
    w_victim     = plru_victim(r_plru[w_fill_idx]);
    for (int unsigned w = 0; w < num_ways; w++) begin
      if (!w_free_found && !r_valid[w_fill_idx][w]) begin
        w_free_found = 1'b1;
        w_victim     = WAY_W'(w);
      end
    end
  end

  // Next-state and output decode; a pending flush blocks the lookup so the
  // refilled line cannot serve before it is invalidated.
  always_comb begin
    w_state_next        = r_state;
    w_flush_now         = 1'b0;
    w_lookup            = 1'b0;
    w_hit_serve         = 1'b0;
    w_miss              = 1'b0;
    w_refill            = 1'b0;
    icache_iddr_read    = 1'b0;
    icache_ifetch_resp  = 1'b0;
    icache_ifetch_rdata = '0;
    case (r_state)
      ST_IDLE: begin
        w_flush_now = ifetch_icache_flush | r_flush_pending;
        w_lookup    = ifetch_icache_read & ~w_flush_now;
        w_hit_serve = w_lookup & w_hit;
        w_miss      = w_lookup & ~w_hit;
        if (w_miss) begin
          w_state_next = ST_FETCH;
        end
        if (w_hit_serve) begin
          icache_ifetch_resp  = 1'b1;
          icache_ifetch_rdata = 32'(w_hit_word);
        end
      end
      ST_FETCH: begin
        icache_iddr_read = 1'b1;
        w_refill         = iddr_icache_resp;
        if (iddr_icache_resp) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Control state, valids, PLRU, miss address and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_iddr_addr     <= '0;
      r_hit_count     <= '0;
      r_miss_count    <= '0;
      r_flush_pending <= 1'b0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      r_state <= w_state_next;
      if (w_miss) begin
        r_iddr_addr <= {ifetch_icache_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
      end
      if (w_hit_serve && (r_hit_count != '1)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss && (r_miss_count != '1)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
      if (w_flush_now) begin
        r_flush_pending <= 1'b0;
        for (int unsigned s = 0; s < NUM_SETS; s++) begin
          r_valid[s] <= '0;
          r_plru[s]  <= '0;
        end
      end else begin
        if (w_hit_serve) begin
          r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
        end
        if (w_refill) begin
          r_valid[w_fill_idx][w_victim] <= 1'b1;
          r_plru[w_fill_idx]            <= plru_touch(r_plru[w_fill_idx], w_victim);
        end
        if ((r_state == ST_FETCH) && ifetch_icache_flush) begin
          r_flush_pending <= 1'b1;
        end
      end
    end
  end

  // Tag and data arrays need no reset; valids gate them
  always_ff @(posedge clk) begin
    if (w_refill) begin
      r_tag[w_fill_idx][w_victim]  <= w_fill_tag;
      r_data[w_fill_idx][w_victim] <= iddr_icache_rdata;
    end
  end

  assign icache_iddr_addr  = r_iddr_addr;
  assign icache_hit_count  = r_hit_count;
  assign icache_miss_count = r_miss_count;

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: stimulus pushes expected fetch data into a
// scoreboard queue, a negedge monitor pops and compares on every resp.
module tb_icache_assoc;

  logic         clk;
  logic         rst;
  logic [31:0]  ifetch_icache_addr;
  logic         ifetch_icache_read;
  logic         ifetch_icache_flush;
  logic [31:0]  icache_ifetch_rdata;
  logic         icache_ifetch_resp;
  logic [31:0]  icache_iddr_addr;
  logic         icache_iddr_read;
  logic [127:0] iddr_icache_rdata;
  logic         iddr_icache_resp;
  logic [31:0]  icache_hit_count;
  logic [31:0]  icache_miss_count;

  icache_assoc #(
    .total_size_bytes(1024),
    .num_ways        (4),
    .line_size_bytes (16),
    .word_size_bytes (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ifetch_icache_addr (ifetch_icache_addr),
    .ifetch_icache_read (ifetch_icache_read),
    .ifetch_icache_flush(ifetch_icache_flush),
    .icache_ifetch_rdata(icache_ifetch_rdata),
    .icache_ifetch_resp (icache_ifetch_resp),
    .icache_iddr_addr   (icache_iddr_addr),
    .icache_iddr_read   (icache_iddr_read),
    .iddr_icache_rdata  (iddr_icache_rdata),
    .iddr_icache_resp   (iddr_icache_resp),
    .icache_hit_count   (icache_hit_count),
    .icache_miss_count  (icache_miss_count)
  );

  int          errors = 0;
  int          checks = 0;
  int          n_served = 0;
  int          n_iddr_cyc = 0;
  int          mem_reqs = 0;
  int          mem_lat = 3;
  logic [31:0] last_iddr_addr = '0;
  logic [31:0] sb_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Line 0x100 carries the pattern from the cold-miss vector; other lines
  // hold 0xC0DE0000 | byte address of each word.
  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [127:0] l;
    if (a == 32'h100) begin
      l = 128'h33333333_22222222_11111111_00000000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        l[k*32 +: 32] = 32'hC0DE_0000 | (a + 32'(k*4));
      end
    end
    return l;
  endfunction

  // DDR model: responds L+1 cycles after iddr_read is first seen
  initial begin
    int cnt;
    cnt = 0;
    iddr_icache_resp  = 1'b0;
    iddr_icache_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (iddr_icache_resp) begin
        iddr_icache_resp = 1'b0;
        cnt = 0;
      end else if (icache_iddr_read) begin
        cnt++;
        if (cnt == mem_lat + 1) begin
          iddr_icache_resp  = 1'b1;
          iddr_icache_rdata = mem_line(icache_iddr_addr);
          mem_reqs++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: scoreboard pop on resp, rdata must be 0 otherwise
  always @(negedge clk) begin
    if (icache_iddr_read) begin
      n_iddr_cyc++;
      last_iddr_addr = icache_iddr_addr;
    end
    if (icache_ifetch_resp) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got rdata %h expected no response", icache_ifetch_rdata);
      end else begin
        check("resp_rdata", icache_ifetch_rdata, sb_q.pop_front());
      end
      n_served++;
    end else if (icache_ifetch_rdata != 32'h0) begin
      check("rdata_idle_zero", icache_ifetch_rdata, 32'h0);
    end
  end

  // Issue one fetch and wait (bounded) for it to be served; exp_lat counts
  // cycles from the first request cycle to the resp cycle.
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input int exp_lat,
                       input bit with_flush, input string name);
    int start;
    int cyc;
    ifetch_icache_addr  = a;
    ifetch_icache_read  = 1'b1;
    ifetch_icache_flush = with_flush;
    start = n_served;
    cyc = 0;
    if (with_flush) begin
      @(negedge clk);
      check({name, "_flush_cycle_resp"}, 32'(icache_ifetch_resp), 32'h0);
      @(posedge clk);
      #1;
      ifetch_icache_flush = 1'b0;
      cyc = 1;
    end
    sb_q.push_back(exp);
    while (n_served == start && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    ifetch_icache_read = 1'b0;
    if (n_served == start) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no resp expected resp after %0d cycles", name, exp_lat);
      sb_q.delete();
    end else begin
      check({name, "_latency"}, 32'(cyc - 1), 32'(exp_lat));
    end
  endtask

  initial begin
    int snap_cyc;
    int snap_reqs;
    rst                 = 1'b1;
    ifetch_icache_addr  = '0;
    ifetch_icache_read  = 1'b0;
    ifetch_icache_flush = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_resp", 32'(icache_ifetch_resp), 32'h0);
    check("rst_iddr_read", 32'(icache_iddr_read), 32'h0);
    check("rst_iddr_addr", icache_iddr_addr, 32'h0);
    check("rst_hit_count", icache_hit_count, 32'h0);
    check("rst_miss_count", icache_miss_count, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cold miss then hit
    mem_lat = 3;
    snap_cyc = n_iddr_cyc;
    fetch(32'h104, 32'h11111111, 5, 1'b0, "cold_miss");
    check("cold_iddr_addr", last_iddr_addr, 32'h100);
    check("cold_iddr_cycles", 32'(n_iddr_cyc - snap_cyc), 32'd4);
    check("cold_miss_count", icache_miss_count, 32'd1);
    fetch(32'h10C, 32'h33333333, 0, 1'b0, "warm_hit");
    check("warm_hit_count", icache_hit_count, 32'd2);

    // Clean slate for the eviction scenario
    ifetch_icache_flush = 1'b1;
    @(posedge clk);
    #1;
    ifetch_icache_flush = 1'b0;

    // PLRU eviction: set 0 filled ways 0..3, 0x000 touched, 0x400 evicts way 2
    mem_lat = 1;
    fetch(32'h000, 32'hC0DE0000, 3, 1'b0, "fill0");
    fetch(32'h100, 32'h00000000, 3, 1'b0, "fill1");
    fetch(32'h200, 32'hC0DE0200, 3, 1'b0, "fill2");
    fetch(32'h300, 32'hC0DE0300, 3, 1'b0, "fill3");
    fetch(32'h000, 32'hC0DE0000, 0, 1'b0, "touch0");
    fetch(32'h400, 32'hC0DE0400, 3, 1'b0, "evict");
    fetch(32'h000, 32'hC0DE0000, 0, 1'b0, "keep0");
    fetch(32'h100, 32'h00000000, 0, 1'b0, "keep1");
    fetch(32'h200, 32'hC0DE0200, 3, 1'b0, "gone2");
    check("plru_hit_count", icache_hit_count, 32'd11);
    check("plru_miss_count", icache_miss_count, 32'd7);

    // Flush in IDLE together with a read
    fetch(32'h100, 32'h00000000, 0, 1'b0, "pre_flush_hit");
    fetch(32'h104, 32'h11111111, 4, 1'b1, "flush_idle");
    check("flush_idle_miss_count", icache_miss_count, 32'd8);
    check("flush_idle_hit_count", icache_hit_count, 32'd13);

    // Flush during FETCH: refill, invalidate, second line read
    mem_lat = 3;
    snap_reqs = mem_reqs;
    fork
      fetch(32'h200, 32'hC0DE0200, 11, 1'b0, "flush_fetch");
      begin
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        ifetch_icache_flush = 1'b1;
        @(posedge clk);
        #1;
        ifetch_icache_flush = 1'b0;
      end
    join
    check("flush_fetch_mem_reqs", 32'(mem_reqs - snap_reqs), 32'd2);
    check("flush_fetch_iddr_addr", last_iddr_addr, 32'h200);
    check("flush_fetch_miss_count", icache_miss_count, 32'd10);

    // Reset asserted mid-FETCH
    ifetch_icache_addr = 32'h300;
    ifetch_icache_read = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_iddr_read", 32'(icache_iddr_read), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_iddr_read", 32'(icache_iddr_read), 32'h0);
    check("mid_rst_hit_count", icache_hit_count, 32'h0);
    check("mid_rst_miss_count", icache_miss_count, 32'h0);
    ifetch_icache_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fetch(32'h104, 32'h11111111, 5, 1'b0, "post_rst_miss");
    check("post_rst_miss_count", icache_miss_count, 32'd1);

    // Hit counter saturation
    force dut.r_hit_count = 32'hFFFF_FFFE;
    release dut.r_hit_count;
    fetch(32'h104, 32'h11111111, 0, 1'b0, "sat_hit0");
    check("sat_hit_count_1", icache_hit_count, 32'hFFFF_FFFF);
    fetch(32'h108, 32'h22222222, 0, 1'b0, "sat_hit1");
    fetch(32'h10C, 32'h33333333, 0, 1'b0, "sat_hit2");
    check("sat_hit_count_3", icache_hit_count, 32'hFFFF_FFFF);
    check("sat_miss_count", icache_miss_count, 32'd1);

    @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised N-way set-associative instruction cache with tree pseudo-LRU replacement, a flush (fence.i) input and hit/miss performance counters. It sits between the fetch stage and the instruction DDR port and succeeds the fixed-geometry instruction cache. Hits return in the request cycle. Misses fetch one full line, refill it, then re-look-up.

## Interface
- total_size_bytes, 1024, total data capacity
- num_ways, 4, associativity; power of two, ≥2
- line_size_bytes, 16, line size; power of two, ≥ word_size_bytes
- word_size_bytes, 4, fetch word size
- Derived: num_sets = total_size_bytes/(line_size_bytes*num_ways); offset bits = log2(line_size_bytes); index bits = log2(num_sets); tag = the remaining bits of the 32-bit address

- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- ifetch_icache_addr  in  32  fetch byte address; word-aligned
- ifetch_icache_read  in  1  fetch request; held with addr until resp
- ifetch_icache_flush  in  1  single-cycle pulse; invalidate all lines
- icache_ifetch_rdata  out  32  fetched word; 0 when resp=0
- icache_ifetch_resp  out  1  request served this cycle
- icache_iddr_addr  out  32  line-aligned miss address
- icache_iddr_read  out  1  line read request; held until resp
- iddr_icache_rdata  in  line_size_bytes*8  refill line; byte 0 in bits [7:0]
- iddr_icache_resp  in  1  line valid; single cycle
- icache_hit_count  out  32  saturating hit counter
- icache_miss_count  out  32  saturating miss counter

## Operation
- Storage: flop-based tag, valid and data arrays, indexed [set][way]. Each set has a PLRU tree of num_ways-1 bits.
- PLRU: bit 0 is the root. For node i, the children are 2i+1 and 2i+2. A bit value of 0 points left, toward the victim side. On access to a way, every node on its path is set to point away from it.
- Victim choice: the lowest-index invalid way if one exists; otherwise the way reached by following the PLRU bits.
- FSM IDLE: the cache looks up when read=1.
  - Hit: resp=1 combinationally; rdata = selected word of the hit way; the set's PLRU is updated; hit_count increments.
  - Miss: iddr_addr is registered as {addr[31:offset], 0}; miss_count increments; the FSM moves to FETCH.
- FSM FETCH: iddr_read=1 and iddr_addr stays stable.
  - On iddr_icache_resp, the victim way's data, tag and valid are written and the PLRU is updated.
  - The FSM then returns to IDLE, which serves the still-held request as a hit.
- Flush in IDLE: all valids and all PLRU bits clear at the clock edge. A read in the same cycle is not served (resp=0) and is re-evaluated the next cycle.
- Flush during FETCH: a pending flag is set. The refill completes, then all valids, including the refilled line, clear on the edge after the refill. The fetch then misses again.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.

## Timing
- Reset values: all valids 0, all PLRU bits 0, state IDLE, pending flush 0, iddr_read 0, iddr_addr 0, resp 0, rdata 0, both counters 0.
- Reset asserted mid-FETCH drops iddr_read immediately (asynchronously). A late iddr_icache_resp after reset is ignored.
- Hit latency: 0 cycles (resp in the same cycle as read).
- Miss latency: with T = cycle read is first seen and memory resp arriving at T+1+L, the fetch resp comes at T+2+L.
- iddr_read rises at T+1 and falls on the cycle after iddr_icache_resp.
- resp is 0 in FETCH and in the refill cycle.
- No new lookup occurs while in FETCH; changes to addr in FETCH are ignored.

## Test plan
Defaults apply: 16 sets, index = addr[7:4], tag = addr[31:8].
- Cold miss, then hit:
  - Stimulus: read 0x104; memory returns 128'h33333333_22222222_11111111_00000000 with L=3.
  - Response: iddr_addr=0x100, iddr_read high 4 cycles, resp with rdata 0x11111111 at T+5, miss_count=1.
  - Follow-up: read 0x10C gives same-cycle resp with 0x33333333 and hit_count=2.
- PLRU eviction:
  - Stimulus: fill 0x000, 0x100, 0x200, 0x300 (ways 0–3), hit 0x000, then read 0x400.
  - Response: the refill lands in way 2.
  - Follow-up: 0x000 and 0x100 hit; 0x200 misses.
- Flush in IDLE:
  - Stimulus: fill 0x100, pulse flush together with read 0x104.
  - Response: resp=0 in the flush cycle; the next cycle misses; miss_count increments.
- Flush during FETCH:
  - Stimulus: pulse flush at T+2 of a 0x200 miss with L=3.
  - Response: the refill completes, then a second iddr_read to 0x200 is issued.
- Reset mid-FETCH:
  - Stimulus: assert rst at T+2 of a miss.
  - Response: iddr_read=0 immediately; counters=0; a read after reset misses.
- Counter saturation:
  - Stimulus: force hit_count to 32'hFFFF_FFFE, then issue 3 hits.
  - Response: hit_count reads 32'hFFFF_FFFF.
